// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: round-robin scheduler sharing one down-counting interval counter among requesters
module counter_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  input  logic                     tick,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_value
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] last, last_n, win, idx;
  logic found;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [CNT_W-1:0] cnt_n;
  logic busy_n;
  // round-robin search starting just after the previous winner
  always_comb begin
    win = last;
    idx = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // state and registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last      <= IW'(NUM_REQ - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cnt_value <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      grant     <= grant_n;
      done      <= done_n;
      busy      <= busy_n;
      cnt_value <= cnt_n;
    end
  end
  // next state: abort beats expiry, DONE always lasts one cycle
  always_comb begin
    state_n = (state == S_IDLE) ? (found ? S_RUN : S_IDLE) :
              (state == S_RUN)  ? (!req[last] ? S_IDLE : (cnt_value == '0) ? S_DONE : S_RUN) :
                                  S_IDLE;
  end
  // next outputs: grant held through RUN, done copies the expiring grant, counter loads at grant
  always_comb begin
    grant_n = (state_n != S_RUN) ? '0 : (state == S_IDLE) ? (ONE << win) : grant;
    done_n  = (state == S_RUN && state_n == S_DONE) ? grant : '0;
    cnt_n   = (state == S_IDLE && found) ? req_len[win*CNT_W +: CNT_W] :
              (state == S_RUN && state_n == S_RUN) ? cnt_value - CNT_W'(tick) : '0;
    last_n  = (state == S_IDLE && found) ? win : last;
    busy_n  = (state_n != S_IDLE);
  end
endmodule

// File: tb/tb_counter_share_arbiter.sv
// tb_counter_share_arbiter: directed vector table plus multi-cycle sequences for the shared counter arbiter
module tb_counter_share_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req;
  logic [31:0] req_len;
  logic tick;
  logic [3:0] grant, done;
  logic busy;
  logic [7:0] cnt_value;
  int vectors = 0;
  int fails = 0;

  counter_share_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .tick(tick),
    .grant(grant), .done(done), .busy(busy), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic        tick;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [7:0]  c;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int glen;
  logic [7:0] expc;

  initial begin
    reset = 1'b0; req = '0; req_len = '0; tick = 1'b0;
    // single requester, len0=3
    tbl[0]  = '{4'h1, 32'h00000003, 1'b1, 4'h1, 4'h0, 1'b1, 8'd3};
    tbl[1]  = '{4'h1, 32'h00000003, 1'b1, 4'h1, 4'h0, 1'b1, 8'd2};
    tbl[2]  = '{4'h1, 32'h00000003, 1'b1, 4'h1, 4'h0, 1'b1, 8'd1};
    tbl[3]  = '{4'h1, 32'h00000003, 1'b1, 4'h1, 4'h0, 1'b1, 8'd0};
    tbl[4]  = '{4'h1, 32'h00000003, 1'b1, 4'h0, 4'h1, 1'b1, 8'd0};
    tbl[5]  = '{4'h0, 32'h00000003, 1'b1, 4'h0, 4'h0, 1'b0, 8'd0};
    tbl[6]  = '{4'h0, 32'h00000003, 1'b1, 4'h0, 4'h0, 1'b0, 8'd0};
    // zero length on requester 2
    tbl[7]  = '{4'h4, 32'h00000000, 1'b1, 4'h4, 4'h0, 1'b1, 8'd0};
    tbl[8]  = '{4'h4, 32'h00000000, 1'b1, 4'h0, 4'h4, 1'b1, 8'd0};
    tbl[9]  = '{4'h0, 32'h00000000, 1'b1, 4'h0, 4'h0, 1'b0, 8'd0};
    // len1=2 with alternate ticks, first tick on the second grant cycle
    tbl[10] = '{4'h2, 32'h00000200, 1'b0, 4'h2, 4'h0, 1'b1, 8'd2};
    tbl[11] = '{4'h2, 32'h00000200, 1'b0, 4'h2, 4'h0, 1'b1, 8'd2};
    tbl[12] = '{4'h2, 32'h00000200, 1'b1, 4'h2, 4'h0, 1'b1, 8'd1};
    tbl[13] = '{4'h2, 32'h00000200, 1'b0, 4'h2, 4'h0, 1'b1, 8'd1};
    tbl[14] = '{4'h2, 32'h00000200, 1'b1, 4'h2, 4'h0, 1'b1, 8'd0};
    tbl[15] = '{4'h2, 32'h00000200, 1'b0, 4'h0, 4'h2, 1'b1, 8'd0};
    tbl[16] = '{4'h0, 32'h00000200, 1'b0, 4'h0, 4'h0, 1'b0, 8'd0};

    do_reset();
    #1;
    chk("reset_grant", 32'(grant), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cnt", 32'(cnt_value), 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req = tbl[i].req; req_len = tbl[i].len; tick = tbl[i].tick;
      step();
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt_value), 32'(tbl[i].c));
    end

    // contention: all four requesting, lens=1, order 0,1,2,3,0
    do_reset();
    req = 4'hF; req_len = 32'h01010101; tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_grant_a", k), 32'(grant), 32'(4'h1 << (k % 4)));
      chk($sformatf("rr%0d_cnt_a", k), 32'(cnt_value), 1);
      step();
      chk($sformatf("rr%0d_grant_b", k), 32'(grant), 32'(4'h1 << (k % 4)));
      step();
      chk($sformatf("rr%0d_done", k), 32'(done), 32'(4'h1 << (k % 4)));
      chk($sformatf("rr%0d_gap1_grant", k), 32'(grant), 0);
      step();
      chk($sformatf("rr%0d_gap2_grant", k), 32'(grant), 0);
      chk($sformatf("rr%0d_gap2_done", k), 32'(done), 0);
      chk($sformatf("rr%0d_gap2_busy", k), 32'(busy), 0);
    end
    @(negedge clk);
    req = '0;
    step();

    // abort requester 3 at cnt 6, pending requester 1 granted next
    do_reset();
    req = 4'h8; req_len = 32'h0A000000; tick = 1'b1;
    step();
    chk("abort_grant", 32'(grant), 32'h8);
    chk("abort_cnt0", 32'(cnt_value), 10);
    repeat (4) step();
    chk("abort_cnt6", 32'(cnt_value), 6);
    @(negedge clk);
    req = 4'h2;
    step();
    chk("abort_grant_off", 32'(grant), 0);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    step();
    chk("abort_next_grant", 32'(grant), 32'h2);
    chk("abort_no_done2", 32'(done), 0);
    step();
    chk("abort_next_done", 32'(done), 32'h2);
    @(negedge clk);
    req = '0;
    step();

    // reset mid-run with grant=0010, cnt=4
    req = 4'h2; req_len = 32'h00000600;
    step();
    chk("rst_run_grant", 32'(grant), 32'h2);
    step();
    step();
    chk("rst_run_cnt", 32'(cnt_value), 4);
    reset = 1'b1;
    #1;
    chk("rst_async_grant", 32'(grant), 0);
    chk("rst_async_done", 32'(done), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_cnt", 32'(cnt_value), 0);
    req = 4'h3;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_after_grant", 32'(grant), 32'h1);
    @(negedge clk);
    req = '0;
    step();
    step();

    // full-range interval: 255 counts, 256 grant cycles, no wrap
    do_reset();
    req = 4'h1; req_len = 32'h000000FF; tick = 1'b1;
    glen = 0;
    expc = 8'd255;
    step();
    while (grant == 4'h1 && glen < 400) begin
      chk($sformatf("wrap_cnt%0d", glen), 32'(cnt_value), 32'(expc));
      expc = expc - 8'd1;
      glen++;
      step();
    end
    chk("wrap_len", glen, 256);
    chk("wrap_done", 32'(done), 32'h1);
    chk("wrap_cnt_end", 32'(cnt_value), 0);
    @(negedge clk);
    req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
